cmb_flag_collector: RTL
=======================

Name: cmb_flag_collector

Overview:
- Downstream consumer of the 16-input/4-output combinational qualifier that produces flags q, r, s, t.
- Samples the four flags on a valid strobe and keeps a saturating high-count per flag.
- Detects flag changes and queues time-indexed change events in a FIFO, drained over a valid/ready handshake by the control/readout logic.

Parameters:
- DEPTH, 8, event FIFO entries; power of 2, minimum 2.
- IDX_W, 8, width of the wrapping sample index carried in each event.
- COUNT_W, 16, width of each per-flag saturating counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  q/r/s/t are valid this cycle and must be sampled.
- q  in  1  flag q from the qualifier.
- r  in  1  flag r.
- s  in  1  flag s.
- t  in  1  flag t.
- clr_cnt  in  1  synchronous clear of all four counters.
- clr_ovf  in  1  synchronous clear of ovf.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head event.
- ev_data  out  IDX_W+8  event word {idx[IDX_W-1:0], flags[3:0]={q,r,s,t}, chg[3:0]}.
- ev_count  out  log2(DEPTH)+1  number of FIFO entries.
- cnt_q  out  COUNT_W  number of samples with q=1.
- cnt_r  out  COUNT_W  number of samples with r=1.
- cnt_s  out  COUNT_W  number of samples with s=1.
- cnt_t  out  COUNT_W  number of samples with t=1.
- ovf  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset clears all state asynchronously:
  - Outputs: ev_valid=0, ev_data=0, ev_count=0, all counters 0, ovf=0.
  - Internal: prev=0, idx=0, first=1, stage-1 valid=0.
- Stage 1, input cycle N: if in_valid, register {q,r,s,t} and the current idx into stage 1; set s1_valid, then idx increments mod 2^IDX_W. If in_valid=0, s1_valid=0.
- Stage 2, cycle N+1, when s1_valid:
  - chg = s1_flags XOR prev.
  - An event is generated if chg != 0 or first=1. When generated because first=1, chg = s1_flags XOR 0.
  - prev <= s1_flags; first <= 0.
  - Each counter whose flag is 1 increments, saturating at all-ones.
- Latency: an event sampled in cycle N is written at the end of N+1. ev_valid is high and ev_data presents it from cycle N+2 at the earliest; counters reflect the sample from cycle N+2.
- Back-to-back samples are accepted every cycle. There is no input backpressure.
- FIFO:
  - First-word-fall-through; ev_data is always the head entry. ev_data is held stable while ev_valid=1 and ev_ready=0.
  - A pop occurs when ev_valid and ev_ready are both high.
  - A push is accepted when ev_count<DEPTH, or when ev_count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the event is dropped and ovf is set. Counters and prev still update on a dropped event.
  - A simultaneous push and pop leaves ev_count unchanged.
  - Pointers wrap mod DEPTH.
- clr_cnt: all counters become 0. If an increment coincides with clr_cnt, the clear wins and the result is 0.
- clr_ovf: ovf becomes 0. If a drop coincides with clr_ovf, ovf becomes 1.
- Reset mid-operation discards FIFO contents and any in-flight stage-1 sample. The next accepted sample is treated as first.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then in_valid pulse with q,r,s,t=0,1,1,0 in cycle 1 -> ev_valid=1 in cycle 3, ev_data={idx=0, flags=0110, chg=0110}; cnt_r=cnt_s=1, cnt_q=cnt_t=0.
- 5 identical samples 0110, then one sample 1110 -> exactly one event total after the first, ev_data={idx=5, flags=1110, chg=1000}; cnt_q=1, cnt_r=6.
- ev_ready=0; 10 alternating samples 0000/1111 (first then 9 changes) with DEPTH=8 -> ev_count=8, ovf=1. Drain 8 -> idx 0..7 in order, then ev_valid=0. clr_ovf -> ovf=0.
- FIFO full, ev_ready=1 and a new event arrive in the same cycle -> push accepted, ev_count stays 8, ovf stays 0.
- COUNT_W=4, 20 samples with t=1 -> cnt_t=15 (saturated). clr_cnt asserted in the same cycle as a t=1 sample -> cnt_t=0.
- rst asserted while 3 events are queued and a sample is in stage 1 -> ev_valid=0 and ev_count=0 immediately. The next sample 0000 produces event {idx=0, flags=0000, chg=0000}.

Source files
------------

// File: rtl/cmb_flag_collector.sv
// Samples the q/r/s/t qualifier flags on in_valid, keeps saturating per-flag
// high counts and queues time-indexed flag-change events in a FWFT FIFO.
module cmb_flag_collector #(
  parameter int DEPTH   = 8,
  parameter int IDX_W   = 8,
  parameter int COUNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     q,
  input  logic                     r,
  input  logic                     s,
  input  logic                     t,
  input  logic                     clr_cnt,
  input  logic                     clr_ovf,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [IDX_W+7:0]         ev_data,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic [COUNT_W-1:0]       cnt_q,
  output logic [COUNT_W-1:0]       cnt_r,
  output logic [COUNT_W-1:0]       cnt_s,
  output logic [COUNT_W-1:0]       cnt_t,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = IDX_W + 8;
  localparam logic [AW:0]      FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT1_C = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR1_C = AW'(1);
  localparam logic [IDX_W-1:0] IDX1_C = IDX_W'(1);
  localparam logic [COUNT_W-1:0] C1_C = COUNT_W'(1);

  // Handshake: an event leaves the FIFO on a cycle where ev_valid and
  // ev_ready are both high; ev_data stays put while ev_ready is low.

  logic             s1_valid;
  logic [3:0]       s1_flags;
  logic [IDX_W-1:0] s1_idx;
  logic [IDX_W-1:0] idx;
  logic [3:0]       prev;
  logic             first;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic [COUNT_W-1:0] cnt [4];

  logic [3:0] chg;
  logic       ev_gen;
  logic       pop;
  logic       push;
  logic       drop;

  // first is only ever set alongside prev=0, but the mux keeps the intent explicit.
  assign chg    = s1_flags ^ (first ? 4'b0000 : prev);
  assign ev_gen = s1_valid && (first || (chg != 4'b0000));
  assign pop    = ev_valid && ev_ready;
  assign push   = ev_gen && ((count != FULL_C) || pop);
  assign drop   = ev_gen && !push;

  // Stage 1: capture flags and the sample index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_flags <= '0;
      s1_idx   <= '0;
      idx      <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_flags <= {q, r, s, t};
        s1_idx   <= idx;
        idx      <= idx + IDX1_C;
      end
    end
  end

  // Stage 2: change detection, counters, FIFO bookkeeping and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= '0;
      first  <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      if (s1_valid) begin
        prev  <= s1_flags;
        first <= 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (clr_cnt)
          cnt[i] <= '0;
        else if (s1_valid && s1_flags[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + C1_C;
      end
      if (push) wr_ptr <= wr_ptr + PTR1_C;
      if (pop)  rd_ptr <= rd_ptr + PTR1_C;
      case ({push, pop})
        2'b10:   count <= count + CNT1_C;
        2'b01:   count <= count - CNT1_C;
        default: count <= count;
      endcase
      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

  // Storage is not reset; ev_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s1_idx, s1_flags, chg};
  end

  assign ev_valid = (count != '0);
  assign ev_data  = ev_valid ? mem[rd_ptr] : '0;
  assign ev_count = count;
  assign cnt_q    = cnt[3];
  assign cnt_r    = cnt[2];
  assign cnt_s    = cnt[1];
  assign cnt_t    = cnt[0];

endmodule
